// File: rtl/button_pkg.sv
// Shared types and widths for the pressure-button controller and its pixel pipeline.
package button_pkg;
    localparam int ROM_ADDR_W = 8;
    localparam int IDX_W      = 4;
    localparam int DEPTH_W    = 4;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_SINKING = 2'd1,
        ST_DOWN    = 2'd2,
        ST_RISING  = 2'd3
    } btn_state_t;
endpackage

// File: rtl/button_pixel_pipe.sv
// Hit test and sprite ROM addressing for the button, with a 2-cycle valid/index pipeline
// matching the one-cycle ROM read latency.
module button_pixel_pipe
    import button_pkg::*;
#(
    parameter int BTN_X = 100,
    parameter int BTN_Y = 200,
    parameter int BTN_W = 32,
    parameter int BTN_H = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [9:0]            draw_x_i,
    input  logic [9:0]            draw_y_i,
    input  logic [DEPTH_W-1:0]    depth_i,
    input  logic [IDX_W-1:0]      sprite_index_i,
    output logic [ROM_ADDR_W-1:0] rom_addr_o,
    output logic [IDX_W-1:0]      pal_index_o,
    output logic                  pix_valid_o
);
    localparam int XSH = $clog2(BTN_W);

    logic [10:0]      px_s, py_s, y_lo_s, rel_x_s, rel_y_s, addr_full_s;
    logic             hit_s;
    logic             hit_q, pix_valid_q;
    logic [IDX_W-1:0] pal_index_d, pal_index_q;

    // Sprite top edge moves down with depth; the bottom edge stays fixed, which clips the sprite.
    always_comb begin
        px_s        = {1'b0, draw_x_i};
        py_s        = {1'b0, draw_y_i};
        y_lo_s      = 11'(BTN_Y) + {7'd0, depth_i};
        rel_x_s     = px_s - 11'(BTN_X);
        rel_y_s     = py_s - y_lo_s;
        hit_s       = (px_s >= 11'(BTN_X)) && (px_s < 11'(BTN_X + BTN_W)) &&
                      (py_s >= y_lo_s) && (py_s < 11'(BTN_Y + BTN_H));
        addr_full_s = (rel_y_s << XSH) + rel_x_s;
        if (hit_s) begin
            rom_addr_o = ROM_ADDR_W'(addr_full_s);
        end else begin
            rom_addr_o = {ROM_ADDR_W{1'b0}};
        end
        if (hit_q) begin
            pal_index_d = sprite_index_i;
        end else begin
            pal_index_d = {IDX_W{1'b0}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pal_index_q <= {IDX_W{1'b0}};
        end else begin
            hit_q       <= hit_s;
            pix_valid_q <= hit_q;
            pal_index_q <= pal_index_d;
        end
    end

    assign pix_valid_o = pix_valid_q;
    assign pal_index_o = pal_index_q;
endmodule

// File: rtl/button_ctrl.sv
// Pressure-button controller: occupancy-driven sink/rise animation FSM, hold-off timer
// before release, and the sprite render path.
module button_ctrl
    import button_pkg::*;
#(
    parameter int BTN_X       = 100,
    parameter int BTN_Y       = 200,
    parameter int BTN_W       = 32,
    parameter int BTN_H       = 8,
    parameter int MAX_DEPTH   = 6,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_tick,
    input  logic                  fire_on,
    input  logic                  water_on,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [IDX_W-1:0]      sprite_index,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [IDX_W-1:0]      pal_index,
    output logic                  pix_valid,
    output logic                  pressed,
    output logic [DEPTH_W-1:0]    depth
);
    localparam int                  HOLD_W     = $clog2(HOLD_FRAMES + 1);
    localparam logic [DEPTH_W-1:0]  DEPTH_MAX  = DEPTH_W'(MAX_DEPTH);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);

    btn_state_t         state_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [HOLD_W-1:0]  hold_q;
    logic               pressed_q;
    logic               occ_s;

    assign occ_s = fire_on | water_on;

    // Everything advances only on vsync so depth is stable across a visible frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_UP;
            depth_q   <= {DEPTH_W{1'b0}};
            hold_q    <= {HOLD_W{1'b0}};
            pressed_q <= 1'b0;
        end else if (frame_tick) begin
            case (state_q)
                ST_UP: begin
                    depth_q <= {DEPTH_W{1'b0}};
                    if (occ_s) state_q <= ST_SINKING;
                end
                ST_SINKING: begin
                    if (!occ_s) begin
                        state_q <= ST_RISING;
                    end else if (depth_q >= DEPTH_MAX - DEPTH_W'(1)) begin
                        depth_q   <= DEPTH_MAX;
                        hold_q    <= {HOLD_W{1'b0}};
                        state_q   <= ST_DOWN;
                        pressed_q <= 1'b1;
                    end else begin
                        depth_q <= depth_q + DEPTH_W'(1);
                    end
                end
                ST_DOWN: begin
                    if (occ_s) begin
                        hold_q <= {HOLD_W{1'b0}};
                    end else if (hold_q >= HOLD_LAST) begin
                        hold_q    <= {HOLD_W{1'b0}};
                        state_q   <= ST_RISING;
                        pressed_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                ST_RISING: begin
                    if (occ_s) begin
                        state_q <= ST_SINKING;
                    end else if (depth_q <= DEPTH_W'(1)) begin
                        depth_q <= {DEPTH_W{1'b0}};
                        state_q <= ST_UP;
                    end else begin
                        depth_q <= depth_q - DEPTH_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_UP;
                    depth_q   <= {DEPTH_W{1'b0}};
                    hold_q    <= {HOLD_W{1'b0}};
                    pressed_q <= 1'b0;
                end
            endcase
        end
    end

    assign pressed = pressed_q;
    assign depth   = depth_q;

    button_pixel_pipe #(
        .BTN_X (BTN_X),
        .BTN_Y (BTN_Y),
        .BTN_W (BTN_W),
        .BTN_H (BTN_H)
    ) u_pixel_pipe (
        .clk_i          (Clk),
        .rst_i          (Reset),
        .draw_x_i       (DrawX),
        .draw_y_i       (DrawY),
        .depth_i        (depth_q),
        .sprite_index_i (sprite_index),
        .rom_addr_o     (rom_addr),
        .pal_index_o    (pal_index),
        .pix_valid_o    (pix_valid)
    );
endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl: FSM depth/pressed steps plus a render scoreboard fed by a ROM model.
module tb_button_ctrl;
    logic       Clk, Reset, frame_tick, fire_on, water_on;
    logic [9:0] DrawX, DrawY;
    logic [3:0] sprite_index, pal_index, depth;
    logic [7:0] rom_addr;
    logic       pix_valid, pressed;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] idx;
    } exp_t;
    exp_t  exp_q[$];
    string tag_q[$];

    button_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .fire_on(fire_on),
        .water_on(water_on), .DrawX(DrawX), .DrawY(DrawY), .sprite_index(sprite_index),
        .rom_addr(rom_addr), .pal_index(pal_index), .pix_valid(pix_valid),
        .pressed(pressed), .depth(depth)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_fn(input logic [7:0] a);
        return a[3:0] ^ a[7:4] ^ 4'h5;
    endfunction

    // Sprite ROM model with one cycle of read latency
    always @(posedge Clk) sprite_index <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic f, input logic w, input logic [3:0] exp_d,
                        input logic exp_p, input string tag);
        @(negedge Clk);
        fire_on = f; water_on = w; frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        chk({tag, "_depth"}, 32'(depth), 32'(exp_d));
        chk({tag, "_pressed"}, 32'(pressed), 32'(exp_p));
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_valid"}, 32'(pix_valid), 32'(e.v));
        chk({t, "_pal"}, 32'(pal_index), 32'(e.idx));
    endtask

    task automatic render_step(input int x, input int y, input logic hit,
                               input logic [7:0] addr, input string tag);
        exp_t e;
        @(negedge Clk);
        if (exp_q.size() >= 2) pop_check();
        DrawX = 10'(x); DrawY = 10'(y);
        #1;
        chk({tag, "_addr"}, 32'(rom_addr), 32'(addr));
        e.v   = hit;
        e.idx = hit ? rom_fn(addr) : 4'd0;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        repeat (2) begin
            @(negedge Clk);
            if (exp_q.size() > 0) pop_check();
        end
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; fire_on = 1'b0; water_on = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        #1;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_pal", 32'(pal_index), 32'd0);
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;

        // Fireboy stands on the button for seven ticks
        tick(1'b1, 1'b0, 4'd0, 1'b0, "sink1");
        tick(1'b1, 1'b0, 4'd1, 1'b0, "sink2");
        tick(1'b1, 1'b0, 4'd2, 1'b0, "sink3");
        tick(1'b1, 1'b0, 4'd3, 1'b0, "sink4");
        tick(1'b1, 1'b0, 4'd4, 1'b0, "sink5");
        tick(1'b1, 1'b0, 4'd5, 1'b0, "sink6");
        tick(1'b1, 1'b0, 4'd6, 1'b1, "sink7");

        // Hold-off: 3 empty, 1 occupied, then 4 empty releases
        tick(1'b0, 1'b1, 4'd6, 1'b1, "down_w");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "hold_e1");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "hold_e2");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "hold_e3");
        tick(1'b0, 1'b1, 4'd6, 1'b1, "hold_w");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "rel_e1");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "rel_e2");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "rel_e3");
        tick(1'b0, 1'b0, 4'd6, 1'b0, "rel_e4");
        tick(1'b0, 1'b0, 4'd5, 1'b0, "rise5");
        tick(1'b0, 1'b0, 4'd4, 1'b0, "rise4");

        // Re-occupied while rising at depth 4
        tick(1'b1, 1'b0, 4'd4, 1'b0, "resink4");
        tick(1'b1, 1'b0, 4'd5, 1'b0, "resink5");
        tick(1'b1, 1'b0, 4'd6, 1'b1, "resink6");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "r2_e1");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "r2_e2");
        tick(1'b0, 1'b0, 4'd6, 1'b1, "r2_e3");
        tick(1'b0, 1'b0, 4'd6, 1'b0, "r2_e4");
        tick(1'b0, 1'b0, 4'd5, 1'b0, "r2_d5");
        tick(1'b0, 1'b0, 4'd4, 1'b0, "r2_d4");
        tick(1'b0, 1'b0, 4'd3, 1'b0, "r2_d3");
        tick(1'b0, 1'b0, 4'd2, 1'b0, "r2_d2");

        // Render at depth 2
        render_step(100, 202, 1'b1, 8'd0,   "d2_topleft");
        render_step(100, 201, 1'b0, 8'd0,   "d2_above");
        render_step(132, 208, 1'b0, 8'd0,   "d2_outside");
        render_step(131, 207, 1'b1, 8'd191, "d2_botright");
        render_step(115, 204, 1'b1, 8'd79,  "d2_mid");
        render_step(99,  203, 1'b0, 8'd0,   "d2_leftout");
        render_step(131, 202, 1'b1, 8'd31,  "d2_topright");
        drain();

        tick(1'b0, 1'b0, 4'd1, 1'b0, "r2_d1");
        tick(1'b0, 1'b0, 4'd0, 1'b0, "r2_d0");
        tick(1'b0, 1'b0, 4'd0, 1'b0, "up_idle");

        // Render fully up
        render_step(100, 200, 1'b1, 8'd0,   "d0_topleft");
        render_step(105, 207, 1'b1, 8'd229, "d0_bot");
        render_step(100, 199, 1'b0, 8'd0,   "d0_above");
        drain();

        // Asynchronous reset mid-SINKING at depth 3 with a lit pixel in flight
        tick(1'b1, 1'b0, 4'd0, 1'b0, "s2_0");
        tick(1'b1, 1'b0, 4'd1, 1'b0, "s2_1");
        tick(1'b1, 1'b0, 4'd2, 1'b0, "s2_2");
        tick(1'b1, 1'b0, 4'd3, 1'b0, "s2_3");
        render_step(100, 203, 1'b1, 8'd0, "d3_top");
        render_step(100, 202, 1'b0, 8'd0, "d3_above");
        render_step(0,   0,   1'b0, 8'd0, "d3_far");
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_depth", 32'(depth), 32'd0);
        chk("arst_pressed", 32'(pressed), 32'd0);
        chk("arst_valid", 32'(pix_valid), 32'd0);
        chk("arst_pal", 32'(pal_index), 32'd0);
        exp_q.delete();
        tag_q.delete();
        @(negedge Clk);
        Reset = 1'b0;
        tick(1'b1, 1'b0, 4'd0, 1'b0, "post_up");
        tick(1'b1, 1'b0, 4'd1, 1'b0, "post_sink");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
